// File: rtl/regfile_pkg.sv
// Shared constants and types for the regfile_sb register file with its
// write-pending scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for RAW hazard detection.
// With REGFILE_BYPASS_EN defined, a same-cycle writeback clears the busy read.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run_i,
  input  logic          iss_en_i,
  input  logic [AW-1:0] iss_rd_i,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [AW-1:0] ra1_i,
  input  logic [AW-1:0] ra2_i,
  output logic          rb1_o,
  output logic          rb2_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             iss_ok, wb_ok;

  assign iss_ok = run_i && iss_en_i && (iss_rd_i != AW'(ZERO_REG));
  assign wb_ok  = run_i && we_i && (wa_i != AW'(ZERO_REG));

  // Set is applied after clear: a newer producer keeps the register pending.
  always_comb begin
    busy_d = busy_q;
    if (wb_ok)  busy_d[wa_i]     = 1'b0;
    if (iss_ok) busy_d[iss_rd_i] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    rb1_o = 1'b0;
    rb2_o = 1'b0;
    if (run_i && ra1_i != AW'(ZERO_REG)) begin
      rb1_o = busy_q[ra1_i];
`ifdef REGFILE_BYPASS_EN
      if (wb_ok && wa_i == ra1_i) rb1_o = iss_ok && (iss_rd_i == ra1_i);
`endif
    end
    if (run_i && ra2_i != AW'(ZERO_REG)) begin
      rb2_o = busy_q[ra2_i];
`ifdef REGFILE_BYPASS_EN
      if (wb_ok && wa_i == ra2_i) rb2_o = iss_ok && (iss_rd_i == ra2_i);
`endif
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with scoreboard and post-reset clear sweep.
// Define REGFILE_BYPASS_EN for write-first forwarding on the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rb1,
  output logic            rb2,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  state_e          state_q;
  logic [AW-1:0]   idx_q;
  logic            ready_q;
  logic [XLEN-1:0] rf_q [NREGS];
  logic            run, wb_ok;

  assign run   = (state_q == RUN);
  assign wb_ok = run && we && (wa != AW'(ZERO_REG));
  assign ready = ready_q;

  // NOTE: state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          idx_q <= idx_q + AW'(1);
          if (idx_q == AW'(NREGS - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN:     ;
        default: state_q <= CLEAR;
      endcase
    end
  end

  // NOTE: the array has no reset; the sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) rf_q[idx_q] <= '0;
      else if (wb_ok)       rf_q[wa]    <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (run && ra1 != AW'(ZERO_REG)) begin
      rd1 = rf_q[ra1];
`ifdef REGFILE_BYPASS_EN
      if (wb_ok && wa == ra1) rd1 = wd;
`endif
    end
    if (run && ra2 != AW'(ZERO_REG)) begin
      rd2 = rf_q[ra2];
`ifdef REGFILE_BYPASS_EN
      if (wb_ok && wa == ra2) rd2 = wd;
`endif
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .run_i    (run),
    .iss_en_i (iss_en),
    .iss_rd_i (iss_rd),
    .we_i     (we),
    .wa_i     (wa),
    .ra1_i    (ra1),
    .ra2_i    (ra2),
    .rb1_o    (rb1),
    .rb2_o    (rb2)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb (default 32 x 32 configuration).
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [4:0]  ra1, ra2, iss_rd, wa;
  logic [31:0] rd1, rd2, wd;
  logic        rb1, rb2, iss_en, we;

  int checks = 0;
  int errors = 0;

  regfile_sb dut (
    .clk    (clk),
    .rst    (rst),
    .ready  (ready),
    .ra1    (ra1),
    .ra2    (ra2),
    .rd1    (rd1),
    .rd2    (rd2),
    .rb1    (rb1),
    .rb2    (rb2),
    .iss_en (iss_en),
    .iss_rd (iss_rd),
    .we     (we),
    .wa     (wa),
    .wd     (wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e_rd1;
    logic        e_rb1;
    logic [31:0] e_rd2;
    logic        e_rb2;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clock until ready rises; returns the number of edges taken (bounded).
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; iss_en = 1'b0; iss_rd = '0;
  endtask

  initial begin
    int cnt;
    // Reads never target a register written in the same row, so these
    // expectations hold with and without bypass.
    vecs[0]  = '{1'b1, 5'd1,  32'h11111111, 1'b0, 5'd0, 5'd2,  5'd0,  32'h0,        1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 5'd2,  32'h22222222, 1'b1, 5'd5, 5'd1,  5'd5,  32'h11111111, 1'b0, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5,  5'd2,  32'h0,        1'b1, 32'h22222222, 1'b0};
    vecs[3]  = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b1, 5'd0, 5'd0,  5'd5,  32'h0,        1'b0, 32'h0,        1'b1};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd5,  32'h0,        1'b0, 32'h0,        1'b1};
    vecs[5]  = '{1'b1, 5'd5,  32'h00001234, 1'b0, 5'd0, 5'd1,  5'd2,  32'h11111111, 1'b0, 32'h22222222, 1'b0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5,  5'd1,  32'h00001234, 1'b0, 32'h11111111, 1'b0};
    vecs[7]  = '{1'b1, 5'd7,  32'h77777777, 1'b1, 5'd7, 5'd5,  5'd6,  32'h00001234, 1'b0, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd5,  32'h77777777, 1'b1, 32'h00001234, 1'b0};
    vecs[9]  = '{1'b1, 5'd9,  32'h00000099, 1'b0, 5'd0, 5'd7,  5'd3,  32'h77777777, 1'b1, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  5'd7,  32'h00000099, 1'b0, 32'h77777777, 1'b1};
    vecs[11] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd9,  5'd8,  32'h00000099, 1'b0, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd31, 5'd30, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0};

    idle();
    ra1 = 5'd3; ra2 = 5'd3;
    rst = 1'b1;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready", {31'b0, ready}, 32'h0);
      check("rst_rd1", rd1, 32'h0);
      check("rst_rb1", {31'b0, rb1}, 32'h0);
    end

    // Sweep with writes/issues driven; they must be ignored.
    rst = 1'b0;
    we = 1'b1; wa = 5'd3; wd = 32'hCAFEF00D; iss_en = 1'b1; iss_rd = 5'd3;
    #1;
    check("clear_rd2", rd2, 32'h0);
    check("clear_rb2", {31'b0, rb2}, 32'h0);
    wait_ready(cnt);
    check("clear_len", cnt, 32);
    idle();
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      check($sformatf("swept_rd1_x%0d", i), rd1, 32'h0);
      check($sformatf("swept_rb1_x%0d", i), {31'b0, rb1}, 32'h0);
    end

    // Table-driven run-mode vectors.
    for (int i = 0; i < 13; i++) begin
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      iss_en = vecs[i].iss_en; iss_rd = vecs[i].iss_rd;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      #1;
      check($sformatf("v%0d_rd1", i), rd1, vecs[i].e_rd1);
      check($sformatf("v%0d_rb1", i), {31'b0, rb1}, {31'b0, vecs[i].e_rb1});
      check($sformatf("v%0d_rd2", i), rd2, vecs[i].e_rd2);
      check($sformatf("v%0d_rb2", i), {31'b0, rb2}, {31'b0, vecs[i].e_rb2});
      tick();
    end
    idle();

    // Reset mid-sweep: mark x4 busy, reset, run 10 sweep steps, reset again.
    iss_en = 1'b1; iss_rd = 5'd4;
    tick();
    idle();
    ra1 = 5'd4;
    #1;
    check("pre_rst_rb1_x4", {31'b0, rb1}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("midsweep_ready", {31'b0, ready}, 32'h0);
    rst = 1'b1;
    tick();
    check("rerst_ready", {31'b0, ready}, 32'h0);
    rst = 1'b0;
    wait_ready(cnt);
    check("resweep_len", cnt, 32);
    ra1 = 5'd4; ra2 = 5'd1;
    #1;
    check("resweep_rb1_x4", {31'b0, rb1}, 32'h0);
    check("resweep_rd2_x1", rd2, 32'h0);

    // Bypass: old value 0x0BAD, then write 0xA5A5A5A5 while reading x3.
    we = 1'b1; wa = 5'd3; wd = 32'h00000BAD;
    tick();
    wd = 32'hA5A5A5A5; ra2 = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_rd2_same", rd2, 32'hA5A5A5A5);
`else
    check("byp_rd2_same", rd2, 32'h00000BAD);
`endif
    check("byp_rb2_same", {31'b0, rb2}, 32'h0);
    tick();
    idle();
    #1;
    check("byp_rd2_next", rd2, 32'hA5A5A5A5);

    // Same-cycle issue and writeback on x3 read through port 1.
    we = 1'b1; wa = 5'd3; wd = 32'h3C3C3C3C; iss_en = 1'b1; iss_rd = 5'd3; ra1 = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_iss_rd1", rd1, 32'h3C3C3C3C);
    check("byp_iss_rb1", {31'b0, rb1}, 32'h1);
`else
    check("byp_iss_rd1", rd1, 32'hA5A5A5A5);
    check("byp_iss_rb1", {31'b0, rb1}, 32'h0);
`endif
    tick();
    idle();
    #1;
    check("iss_wb_rd1_next", rd1, 32'h3C3C3C3C);
    check("iss_wb_rb1_next", {31'b0, rb1}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-register file with an integrated write-pending scoreboard and a sequential clear engine, for the pipelined RV32I core. It provides two combinational read ports and one synchronous write port. Per-register busy bits let decode stall on RAW hazards. After reset it zeroes the array one entry per cycle, so no parallel reset fan-out is needed on the storage.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥4)
- AW, $clog2(NREGS), register address width (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- ready  out  1  high once the clear sweep is complete; accesses are legal only while high
- ra1, ra2  in  AW each  read addresses
- rd1, rd2  out  XLEN each  read data, combinational
- rb1, rb2  out  1 each  busy flag of ra1/ra2, combinational
- iss_en  in  1  issue: mark iss_rd busy
- iss_rd  in  AW  destination register of the issuing instruction
- we  in  1  writeback enable
- wa  in  AW  writeback address
- wd  in  XLEN  writeback data; a writeback also clears the busy bit of wa

## Operation
- The FSM has two states: CLEAR and RUN.
- rst high (any state, including mid-sweep):
  - state goes to CLEAR and the sweep index goes to 0
  - all busy bits clear; ready goes to 0
- CLEAR with rst low:
  - each cycle, rf[idx] is set to 0 and idx increments
  - after rf[NREGS-1] is written, the next state is RUN and ready goes to 1
- While in CLEAR:
  - we and iss_en are ignored
  - rd1/rd2 are forced to 0 and rb1/rb2 are forced to 0
- RUN, write: when we=1 and wa≠0, rf[wa] is set to wd and busy[wa] is set to 0.
- RUN, issue: when iss_en=1 and iss_rd≠0, busy[iss_rd] is set to 1.
- Issue and writeback to the same register in the same cycle: issue wins and busy stays 1, because the newer producer is pending.
- Register 0:
  - always reads 0 and is never busy
  - writes to and issues on register 0 are dropped
- Reads of register 0 return 0 regardless of bypass.
- A writeback to a register that is not busy is legal: data is written and busy stays 0.

## Timing
- Read latency is 0 cycles (combinational from ra/rf/busy).
- Write and issue latency: the effect is visible from the cycle after the edge unless bypass is enabled (see Configuration).
- Clear duration: ready rises exactly NREGS cycles after the first rising edge sampled with rst low.
  - NREGS=32: rst low at edge 0 → ready=1 after edge 31, i.e. visible in cycle 32.
- Reset values:
  - ready=0
  - rb1/rb2=0
  - rd1/rd2=0
  - busy vector all 0
- Array contents are undefined until the sweep reaches each entry.
- Address inputs are full AW bits, so no out-of-range addresses exist.

## Configuration
- REGFILE_BYPASS_EN defined (write-first forwarding):
  - if we=1, wa≠0 and ra==wa in RUN, then rd equals wd in the same cycle
  - rb for that port reads 0 unless iss_en targets the same register in the same cycle, in which case it reads 1
- REGFILE_BYPASS_EN undefined:
  - rd returns the stored value and rb the registered busy bit
  - the written value and the cleared busy bit are visible from the next cycle

## Structure
- Package regfile_pkg holds:
  - default XLEN and NREGS constants
  - the FSM state enum (CLEAR, RUN)
  - the ZERO_REG constant
- Sub-module regfile_scoreboard holds:
  - the NREGS-bit busy vector
  - set/clear priority logic
  - the two busy read ports and the bypass clear term
- The top level holds the storage array, the clear FSM/index, the data read muxes and the data bypass.

## Test plan
- Clear timing: assert rst 3 cycles then release → ready=0 for exactly 32 cycles, then 1; every address reads 0 and rb=0.
- Reset mid-sweep: assert rst at sweep idx=10 for 1 cycle → idx restarts at 0; ready rises 32 cycles after release.
- Register 0: we=1, wa=0, wd=0xDEADBEEF → rd1(ra1=0)=0; iss_en on x0 → rb1=0.
- Scoreboard:
  - iss x5 → rb1(ra1=5)=1 next cycle
  - writeback x5 with 0x1234 → rb1=0 and rd1=0x1234 afterwards
- Simultaneous issue and writeback to x7 → busy[7]=1 next cycle and rf[7]=wd.
- Bypass: write x3=0xA5A5A5A5 with ra2=3 in the same cycle:
  - with REGFILE_BYPASS_EN: rd2=0xA5A5A5A5 in that cycle
  - without it: rd2 holds the old value in that cycle and shows 0xA5A5A5A5 in the next cycle
